nv_nvdla_hls_shiftleftsat_pipe: RTL and testbench
=================================================

Name: nv_nvdla_hls_shiftleftsat_pipe

Overview:
- Pipelined signed left-shift with saturation. It is the up-scaling counterpart of the right-shift/round/saturate helper used on SDP and CDP output paths.
- Takes a signed IN_WIDTH operand and a per-transfer shift count. Produces a signed OUT_WIDTH result, clamped to the OUT_WIDTH range, with a per-transfer saturation flag.
- Two register stages with valid/ready handshake on both sides.
- A saturating event counter feeds a status register.

Parameters:
- IN_WIDTH, 16, signed input operand width.
- OUT_WIDTH, 32, signed output width; must be > IN_WIDTH.
- SHIFT_WIDTH, 5, shift-count width; legal shifts are 0..2^SHIFT_WIDTH-1.

Ports:
- nvdla_core_clk  input  1  core clock.
- nvdla_core_rst  input  1  synchronous reset, active-high.
- in_pvld  input  1  input transfer valid.
- in_prdy  output  1  input transfer ready.
- in_data  input  IN_WIDTH  signed operand.
- in_shift  input  SHIFT_WIDTH  left-shift count.
- out_pvld  output  1  result valid.
- out_prdy  input  1  downstream ready.
- out_data  output  OUT_WIDTH  shifted/saturated result.
- out_sat  output  1  result was clamped.
- sat_cnt_clr  input  1  clear saturation counter.
- sat_cnt  output  32  number of saturated results accepted downstream.

Behaviour:
- Transfers:
  - Input transfer occurs when in_pvld & in_prdy.
  - Output transfer occurs when out_pvld & out_prdy.
  - A valid stage holds its data stable until it is consumed; no drops, no reordering.
- Stage 1 (S1):
  - Registers in_data and in_shift, and sets s1_vld.
  - in_prdy = ~s1_vld | s2_ready, where s2_ready = ~out_pvld | out_prdy.
  - in_prdy is combinational from out_prdy. Full throughput: one transfer per cycle is sustained when out_prdy is held high.
- Stage 2 (S2) arithmetic, computed from the S1 registers and registered into S2:
  - Extended value E = sign_ext(s1_data) << s1_shift, width IN_WIDTH + 2^SHIFT_WIDTH - 1, exact.
  - Saturation: sat = bits [top:OUT_WIDTH-1] of E are not all equal. This means overflow of the signed OUT_WIDTH range.
  - If sat: out_data = 0 followed by all 1s (max positive) when s1_data is positive; 1 followed by all 0s (min negative) when negative.
  - Else: out_data = E[OUT_WIDTH-1:0].
  - Zero input never saturates, for any shift.
  - Shift 0 gives the sign-extended input unchanged.
- Latency: a result appears at out_pvld exactly 2 cycles after its input transfer when there is no backpressure.
- Backpressure: with out_prdy low, S2 holds. S1 fills, then in_prdy drops in the following cycle. No bubble on release.
- Counter sat_cnt:
  - Increments by 1 on each output transfer with out_sat = 1.
  - Saturates at 0xFFFFFFFF; does not wrap.
  - sat_cnt_clr takes priority. If a clear and an increment event fall in the same cycle, sat_cnt becomes 1. A clear alone gives 0.
- Reset values: s1_vld = 0, out_pvld = 0, out_data = 0, out_sat = 0, sat_cnt = 0.
- Reset timing:
  - in_prdy = 1 in the first cycle after reset deasserts. It is also 1 while reset is asserted, but any transfer in that cycle is discarded.
  - Reset mid-operation flushes both stages immediately. In-flight data is lost, and out_pvld = 0 the cycle after reset is sampled.
- No X propagation: out_data and out_sat are only updated on S2 load. Held values are stable while out_pvld & ~out_prdy.

Test Plan:
- Single transfer, IN=16/OUT=32, data 0x0003, shift 4, out_prdy = 1 -> out_pvld rises 2 cycles later; out_data = 0x00000030; out_sat = 0; sat_cnt = 0.
- Negative operand, data 0x8000 (-32768), shift 16 -> out_data = 0x80000000, out_sat = 0. Same operand with shift 17 -> out_data = 0x80000000, out_sat = 1, sat_cnt = 1.
- Positive overflow, data 0x7FFF, shift 17 -> out_data = 0x7FFFFFFF, out_sat = 1. Data 0x0000, shift 31 -> out_data = 0, out_sat = 0.
- Streaming 16 back-to-back inputs, then out_prdy low for 5 cycles mid-stream -> in_prdy drops one cycle after S1 fills. All 16 results emerge in order, none duplicated or lost. Throughput returns to 1/cycle on release.
- sat_cnt_clr asserted in the same cycle as a saturated output transfer -> sat_cnt = 1. Preload the counter to 0xFFFFFFFF via 2^32-1 forced events (or a force in the bench), then one more saturated transfer -> sat_cnt stays 0xFFFFFFFF.
- Assert nvdla_core_rst with both stages full and out_prdy low -> next cycle out_pvld = 0, out_data = 0, out_sat = 0, sat_cnt = 0, in_prdy = 1. A new input then produces a correct result after 2 cycles.

Source files
------------

// File: rtl/nv_nvdla_hls_shiftleftsat_pipe_if.sv
// nv_nvdla_hls_shiftleftsat_pipe_if: input/output handshakes and counter status of the shift-left-saturate pipe
interface nv_nvdla_hls_shiftleftsat_pipe_if #(
  parameter int IN_WIDTH    = 16,
  parameter int OUT_WIDTH   = 32,
  parameter int SHIFT_WIDTH = 5
);
  logic                   in_pvld;
  logic                   in_prdy;
  logic [IN_WIDTH-1:0]    in_data;
  logic [SHIFT_WIDTH-1:0] in_shift;
  logic                   out_pvld;
  logic                   out_prdy;
  logic [OUT_WIDTH-1:0]   out_data;
  logic                   out_sat;
  logic                   sat_cnt_clr;
  logic [31:0]            sat_cnt;
  modport master (
    output in_pvld, in_data, in_shift, out_prdy, sat_cnt_clr,
    input  in_prdy, out_pvld, out_data, out_sat, sat_cnt
  );
  modport slave (
    input  in_pvld, in_data, in_shift, out_prdy, sat_cnt_clr,
    output in_prdy, out_pvld, out_data, out_sat, sat_cnt
  );
endinterface

// File: rtl/nv_nvdla_hls_shiftleftsat_pipe.sv
// nv_nvdla_hls_shiftleftsat_pipe: two-stage signed left shift with saturation and saturated-result counter
module nv_nvdla_hls_shiftleftsat_pipe #(
  parameter int IN_WIDTH    = 16,
  parameter int OUT_WIDTH   = 32,
  parameter int SHIFT_WIDTH = 5
) (
  input logic nvdla_core_clk,
  input logic nvdla_core_rst,
  nv_nvdla_hls_shiftleftsat_pipe_if.slave io
);
  localparam int EW = IN_WIDTH + 2**SHIFT_WIDTH - 1;
  logic                   s1_vld_q, s1_vld_d;
  logic [IN_WIDTH-1:0]    s1_data_q, s1_data_d;
  logic [SHIFT_WIDTH-1:0] s1_shift_q, s1_shift_d;
  logic                   out_pvld_q, out_pvld_d;
  logic [OUT_WIDTH-1:0]   out_data_q, out_data_d;
  logic                   out_sat_q, out_sat_d;
  logic [31:0]            sat_cnt_q, sat_cnt_d;
  logic                   s2_ready, in_rdy, in_xfer, s2_load, sat, sat_inc;
  logic [EW-1:0]          ext;
  logic [OUT_WIDTH-1:0]   clamp;
  always_comb begin
    s2_ready   = ~out_pvld_q | io.out_prdy;
    in_rdy     = nvdla_core_rst | ~s1_vld_q | s2_ready;
    in_xfer    = io.in_pvld & in_rdy;
    s2_load    = s1_vld_q & s2_ready;
    s1_vld_d   = in_xfer | (s1_vld_q & ~s2_ready);
    s1_data_d  = in_xfer ? io.in_data : s1_data_q;
    s1_shift_d = in_xfer ? io.in_shift : s1_shift_q;
    // exact product: every bit above the output sign bit must match it
    ext        = {{(EW-IN_WIDTH){s1_data_q[IN_WIDTH-1]}}, s1_data_q} << s1_shift_q;
    sat        = ~(&ext[EW-1:OUT_WIDTH-1] | ~|ext[EW-1:OUT_WIDTH-1]);
    clamp      = s1_data_q[IN_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}} : {1'b0, {(OUT_WIDTH-1){1'b1}}};
    out_pvld_d = s2_load | (out_pvld_q & ~io.out_prdy);
    out_data_d = s2_load ? (sat ? clamp : ext[OUT_WIDTH-1:0]) : out_data_q;
    out_sat_d  = s2_load ? sat : out_sat_q;
    sat_inc    = out_pvld_q & io.out_prdy & out_sat_q;
    sat_cnt_d  = io.sat_cnt_clr ? {31'b0, sat_inc} : sat_cnt_q + {31'b0, sat_inc & ~&sat_cnt_q};
  end
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      s1_vld_q   <= 1'b0;
      s1_data_q  <= '0;
      s1_shift_q <= '0;
      out_pvld_q <= 1'b0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
      sat_cnt_q  <= '0;
    end else begin
      s1_vld_q   <= s1_vld_d;
      s1_data_q  <= s1_data_d;
      s1_shift_q <= s1_shift_d;
      out_pvld_q <= out_pvld_d;
      out_data_q <= out_data_d;
      out_sat_q  <= out_sat_d;
      sat_cnt_q  <= sat_cnt_d;
    end
  end
  assign io.in_prdy  = in_rdy;
  assign io.out_pvld = out_pvld_q;
  assign io.out_data = out_data_q;
  assign io.out_sat  = out_sat_q;
  assign io.sat_cnt  = sat_cnt_q;
endmodule

// File: tb/tb_nv_nvdla_hls_shiftleftsat_pipe.sv
// tb_nv_nvdla_hls_shiftleftsat_pipe: directed vectors against an arithmetic reference model
module tb_nv_nvdla_hls_shiftleftsat_pipe;
  localparam longint MAXV = 64'sh7FFF_FFFF;
  localparam longint MINV = -64'sh8000_0000;
  typedef struct {logic [31:0] d; logic s;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  exp_t q[$];
  exp_t e;
  logic [31:0] mcnt = '0;
  logic inc;
  logic acc;
  always #5 clk = ~clk;
  nv_nvdla_hls_shiftleftsat_pipe_if #(.IN_WIDTH(16), .OUT_WIDTH(32), .SHIFT_WIDTH(5)) io ();
  nv_nvdla_hls_shiftleftsat_pipe #(.IN_WIDTH(16), .OUT_WIDTH(32), .SHIFT_WIDTH(5)) dut (
    .nvdla_core_clk(clk),
    .nvdla_core_rst(rst),
    .io(io.slave)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic exp_t model(input logic [15:0] d, input logic [4:0] s);
    exp_t r;
    longint v;
    v = longint'($signed(d)) * (64'sd1 <<< s);
    r.s = (v > MAXV) || (v < MINV);
    r.d = (v > MAXV) ? 32'h7FFF_FFFF : (v < MINV) ? 32'h8000_0000 : v[31:0];
    return r;
  endfunction
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      mcnt = '0;
    end else begin
      chk("sat_cnt", io.sat_cnt, mcnt);
      inc = 1'b0;
      if (io.out_pvld) begin
        if (q.size() == 0) chk("spurious_out_pvld", io.out_pvld, 0);
        else begin
          chk("out_data", io.out_data, q[0].d);
          chk("out_sat", io.out_sat, q[0].s);
          if (io.out_prdy) begin
            inc = q[0].s;
            void'(q.pop_front());
          end
        end
      end
      if (io.sat_cnt_clr) mcnt = {31'b0, inc};
      else if (inc && mcnt != 32'hFFFF_FFFF) mcnt = mcnt + 1;
      if (io.in_pvld && io.in_prdy) begin
        e = model(io.in_data, io.in_shift);
        q.push_back(e);
      end
    end
  end
  task automatic lit(input logic [15:0] d, input logic [4:0] s, input logic [31:0] xd, input logic xs);
    io.in_pvld = 1'b1;
    io.in_data = d;
    io.in_shift = s;
    @(negedge clk);
    chk("lit_in_prdy", io.in_prdy, 1);
    @(posedge clk); #1;
    io.in_pvld = 1'b0;
    chk("lit_not_early", io.out_pvld, 0);
    @(posedge clk); #1;
    chk("lit_out_pvld", io.out_pvld, 1);
    chk("lit_out_data", io.out_data, xd);
    chk("lit_out_sat", io.out_sat, xs);
  endtask
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    int i;
    int c;
    io.in_pvld = 1'b0;
    io.in_data = '0;
    io.in_shift = '0;
    io.out_prdy = 1'b1;
    io.sat_cnt_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_prdy", io.in_prdy, 1);
    chk("rst_out_pvld", io.out_pvld, 0);
    chk("rst_out_data", io.out_data, 0);
    chk("rst_out_sat", io.out_sat, 0);
    chk("rst_sat_cnt", io.sat_cnt, 0);
    rst = 1'b0;
    lit(16'h0003, 5'd4, 32'h0000_0030, 1'b0);
    lit(16'h8000, 5'd16, 32'h8000_0000, 1'b0);
    lit(16'h8000, 5'd17, 32'h8000_0000, 1'b1);
    @(posedge clk); #1;
    chk("sat_cnt_after_neg_sat", io.sat_cnt, 1);
    lit(16'h7FFF, 5'd17, 32'h7FFF_FFFF, 1'b1);
    lit(16'h0000, 5'd31, 32'h0000_0000, 1'b0);
    lit(16'hFFFF, 5'd31, 32'h8000_0000, 1'b0);
    lit(16'h0001, 5'd30, 32'h4000_0000, 1'b0);
    lit(16'h0001, 5'd31, 32'h7FFF_FFFF, 1'b1);
    lit(16'h1234, 5'd0, 32'h0000_1234, 1'b0);
    @(posedge clk); #1;
    chk("sat_cnt_after_lits", io.sat_cnt, 3);
    i = 0;
    c = 0;
    while (i < 16 && c < 100) begin
      io.out_prdy = !(c >= 5 && c < 10);
      io.in_pvld = 1'b1;
      io.in_data = 16'(i * 4099 + 1);
      io.in_shift = 5'(i * 7);
      @(negedge clk);
      if (c == 7) chk("stall_in_prdy", io.in_prdy, 0);
      if (c == 10) chk("release_in_prdy", io.in_prdy, 1);
      acc = io.in_prdy;
      @(posedge clk); #1;
      if (acc) i++;
      c++;
    end
    io.in_pvld = 1'b0;
    io.out_prdy = 1'b1;
    chk("stream_cycles", c, 21);
    repeat (4) @(posedge clk);
    #1;
    chk("stream_drained", q.size(), 0);
    lit(16'h7FFF, 5'd20, 32'h7FFF_FFFF, 1'b1);
    io.sat_cnt_clr = 1'b1;
    @(posedge clk); #1;
    io.sat_cnt_clr = 1'b0;
    chk("clr_with_inc", io.sat_cnt, 1);
    io.sat_cnt_clr = 1'b1;
    @(posedge clk); #1;
    io.sat_cnt_clr = 1'b0;
    chk("clr_alone", io.sat_cnt, 0);
    force dut.sat_cnt_q = 32'hFFFF_FFFF;
    mcnt = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    release dut.sat_cnt_q;
    chk("preload", io.sat_cnt, 32'hFFFF_FFFF);
    lit(16'h4000, 5'd31, 32'h7FFF_FFFF, 1'b1);
    @(posedge clk); #1;
    chk("cnt_sticks_at_max", io.sat_cnt, 32'hFFFF_FFFF);
    io.out_prdy = 1'b0;
    io.in_pvld = 1'b1;
    io.in_data = 16'h0011;
    io.in_shift = 5'd2;
    @(posedge clk); #1;
    io.in_data = 16'h0022;
    @(posedge clk); #1;
    io.in_data = 16'h0033;
    chk("full_in_prdy", io.in_prdy, 0);
    chk("full_out_data", io.out_data, 32'h44);
    rst = 1'b1;
    #1;
    chk("in_prdy_during_rst", io.in_prdy, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    io.in_pvld = 1'b0;
    io.out_prdy = 1'b1;
    chk("flush_out_pvld", io.out_pvld, 0);
    chk("flush_out_data", io.out_data, 0);
    chk("flush_out_sat", io.out_sat, 0);
    chk("flush_sat_cnt", io.sat_cnt, 0);
    chk("flush_in_prdy", io.in_prdy, 1);
    lit(16'hFFFD, 5'd3, 32'hFFFF_FFE8, 1'b0);
    @(posedge clk); #1;
    chk("final_empty", q.size(), 0);
    chk("final_idle", io.out_pvld, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
